// File: rtl/sd_capture_scheduler_pkg.sv
// Shared types for the SD capture scheduler: writer FSM states and block geometry.
package sd_capture_pkg;

    localparam int SD_BLOCK_BYTES = 512;
    localparam int SD_BYTE_IDX_W  = $clog2(SD_BLOCK_BYTES);

    typedef enum logic [1:0] {
        W_IDLE,
        W_START,
        W_STREAM,
        W_WAIT_DONE
    } wr_state_t;

endpackage

// File: rtl/sd_capture_scheduler_if.sv
// Block-write handshake between the capture scheduler (master) and the SD card controller (slave).
interface sd_capture_scheduler_if;

    logic        sd_ready;
    logic        sd_start;
    logic [31:0] sd_addr;
    logic        sd_byte_req;
    logic [7:0]  sd_byte;
    logic        sd_byte_valid;
    logic        sd_done;

    modport master (
        input  sd_ready, sd_byte_req, sd_done,
        output sd_start, sd_addr, sd_byte, sd_byte_valid
    );

    modport slave (
        output sd_ready, sd_byte_req, sd_done,
        input  sd_start, sd_addr, sd_byte, sd_byte_valid
    );

endinterface

// File: rtl/sd_capture_scheduler_fifo.sv
// Single-clock FIFO with registered read data; push is refused when full, pop when empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Fullness is judged before this cycle's pop, so a simultaneous pop never frees space for a push.
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
        if (do_pop)  dout        <= mem[rd_ptr];
    end

endmodule

// File: rtl/sd_capture_scheduler.sv
// Buffers triggered ADC samples and writes them to the SD card as consecutive 512-byte blocks.
module sd_capture_scheduler
    import sd_capture_pkg::*;
#(
    parameter int          FIFO_DEPTH     = 1024,
    parameter int          CAPTURE_BLOCKS = 16,
    parameter logic [31:0] BASE_BLOCK     = 32'd2048,
    parameter logic [31:0] REGION_BLOCKS  = 32'd65536
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          trigger,
    input  logic                          axiiv,
    input  logic [7:0]                    axiid,
    sd_capture_scheduler_if.master        sd,
    output logic                          busy,
    output logic [15:0]                   drop_count,
    output logic [15:0]                   blocks_written
);

    localparam int TOTAL = CAPTURE_BLOCKS * SD_BLOCK_BYTES;
    localparam int EW    = $clog2(TOTAL) + 1;
    localparam int CW    = $clog2(FIFO_DEPTH) + 1;

    localparam logic [EW-1:0]            TOTAL_C   = EW'(TOTAL);
    localparam logic [CW-1:0]            BLOCK_C   = CW'(SD_BLOCK_BYTES);
    localparam logic [SD_BYTE_IDX_W-1:0] LAST_BYTE = SD_BYTE_IDX_W'(SD_BLOCK_BYTES - 1);
    localparam logic [31:0]              ADDR_END  = BASE_BLOCK + REGION_BLOCKS;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [31:0] next_addr(input logic [31:0] a);
        logic [31:0] n;
        n = a + 32'd1;
        return (n == ADDR_END) ? BASE_BLOCK : n;
    endfunction

    logic                     trigger_q;
    logic                     trig_edge;
    logic                     capture_active;
    logic [EW-1:0]            enq_cnt;
    logic                     push;
    logic                     pop;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [CW-1:0]            fifo_count;
    logic [7:0]               fifo_dout;
    wr_state_t                state;
    logic [SD_BYTE_IDX_W-1:0] byte_cnt;
    logic                     byte_sel;

    assign trig_edge = trigger & ~trigger_q;
    assign push      = capture_active & axiiv & ~fifo_full;
    assign pop       = (state == W_STREAM) & sd.sd_byte_req;
    assign busy      = capture_active | ~fifo_empty | (state != W_IDLE);

    // Read data is forced to zero unless the previous cycle actually popped the FIFO.
    assign sd.sd_byte = byte_sel ? fifo_dout : 8'h00;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (axiid),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Capture side: edge detect, length counting and overflow accounting.
    always_ff @(posedge clk) begin
        if (rst) begin
            trigger_q      <= 1'b0;
            capture_active <= 1'b0;
            enq_cnt        <= '0;
            drop_count     <= '0;
        end else begin
            trigger_q <= trigger;
            if (trig_edge && !busy) begin
                capture_active <= 1'b1;
                enq_cnt        <= '0;
            end else if (push) begin
                enq_cnt <= enq_cnt + 1'b1;
                if (enq_cnt + 1'b1 == TOTAL_C) capture_active <= 1'b0;
            end
            if (capture_active && axiiv && fifo_full) drop_count <= sat_inc16(drop_count);
        end
    end

    // Writer side: one SD block per pass through the FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= W_IDLE;
            byte_cnt         <= '0;
            byte_sel         <= 1'b0;
            blocks_written   <= '0;
            sd.sd_start      <= 1'b0;
            sd.sd_addr       <= BASE_BLOCK;
            sd.sd_byte_valid <= 1'b0;
        end else begin
            sd.sd_start      <= 1'b0;
            sd.sd_byte_valid <= sd.sd_byte_req;
            byte_sel         <= pop;
            case (state)
                W_IDLE: begin
                    if (fifo_count >= BLOCK_C) state <= W_START;
                end
                W_START: begin
                    if (sd.sd_ready) begin
                        sd.sd_start <= 1'b1;
                        byte_cnt    <= '0;
                        state       <= W_STREAM;
                    end
                end
                W_STREAM: begin
                    if (sd.sd_byte_req) begin
                        byte_cnt <= byte_cnt + 1'b1;
                        if (byte_cnt == LAST_BYTE) state <= W_WAIT_DONE;
                    end
                end
                W_WAIT_DONE: begin
                    if (sd.sd_done) begin
                        blocks_written <= blocks_written + 16'd1;
                        sd.sd_addr     <= next_addr(sd.sd_addr);
                        state          <= W_IDLE;
                    end
                end
                default: state <= W_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_capture_scheduler.sv
// Scoreboard bench: stimulus queues expected addresses/bytes, a monitor pops and compares them.
module tb_sd_capture_scheduler;

    localparam int          DEPTH   = 1024;
    localparam int          CBLK    = 4;
    localparam logic [31:0] BASE    = 32'd2048;
    localparam logic [31:0] REGION  = 32'd3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        trigger = 1'b0;
    logic        axiiv = 1'b0;
    logic [7:0]  axiid = 8'h00;
    logic        busy;
    logic [15:0] drop_count;
    logic [15:0] blocks_written;

    logic ready_en   = 1'b1;
    logic ctrl_busy  = 1'b0;
    logic ctrl_req   = 1'b0;
    logic ctrl_done  = 1'b0;
    logic stray_req  = 1'b0;
    logic stray_done = 1'b0;

    sd_capture_scheduler_if sd ();

    assign sd.sd_ready    = ready_en & ~ctrl_busy;
    assign sd.sd_byte_req = ctrl_req | stray_req;
    assign sd.sd_done     = ctrl_done | stray_done;

    sd_capture_scheduler #(
        .FIFO_DEPTH     (DEPTH),
        .CAPTURE_BLOCKS (CBLK),
        .BASE_BLOCK     (BASE),
        .REGION_BLOCKS  (REGION)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .trigger        (trigger),
        .axiiv          (axiiv),
        .axiid          (axiid),
        .sd             (sd),
        .busy           (busy),
        .drop_count     (drop_count),
        .blocks_written (blocks_written)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  exp_bytes[$];
    logic [31:0] exp_addrs[$];
    int          zero_pend = 0;
    int          starts_seen = 0;
    int          bytes_seen = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Monitor: outputs settle after the rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sd.sd_start) begin
                starts_seen++;
                if (exp_addrs.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_start: addr 0x%0h with none expected at %0t", sd.sd_addr, $time);
                end else begin
                    check("start_addr", sd.sd_addr, exp_addrs.pop_front());
                end
            end
            if (sd.sd_byte_valid) begin
                bytes_seen++;
                if (zero_pend > 0) begin
                    zero_pend--;
                    check("stray_byte", {24'h0, sd.sd_byte}, 32'h0);
                end else if (exp_bytes.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte: 0x%0h with none expected at %0t", sd.sd_byte, $time);
                end else begin
                    check("byte", {24'h0, sd.sd_byte}, {24'h0, exp_bytes.pop_front()});
                end
            end
        end
    end

    // Controller model: 512 back-to-back byte requests per block, then sd_done.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && sd.sd_start) begin
                bit aborted;
                aborted   = 1'b0;
                ctrl_busy = 1'b1;
                for (int i = 0; i < 512; i++) begin
                    if (rst) begin
                        aborted = 1'b1;
                        break;
                    end
                    ctrl_req = 1'b1;
                    @(negedge clk);
                end
                ctrl_req = 1'b0;
                repeat (2) @(negedge clk);
                if (!aborted && !rst) begin
                    ctrl_done = 1'b1;
                    @(negedge clk);
                    ctrl_done = 1'b0;
                end
                ctrl_busy = 1'b0;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic pulse_trigger();
        trigger = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
    endtask

    task automatic send(input int n, input int base, input int gap, input int n_exp, input int trig_at);
        for (int k = 0; k < n; k++) begin
            axiiv = 1'b1;
            axiid = 8'(base + k);
            if (k < n_exp) exp_bytes.push_back(8'(base + k));
            trigger = (k == trig_at);
            @(negedge clk);
            axiiv   = 1'b0;
            trigger = 1'b0;
            repeat (gap) @(negedge clk);
        end
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while (busy && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("busy_fall", {31'h0, busy}, 32'h0);
    endtask

    task automatic push_addrs(input logic [31:0] a0, input logic [31:0] a1,
                              input logic [31:0] a2, input logic [31:0] a3);
        exp_addrs.push_back(a0);
        exp_addrs.push_back(a1);
        exp_addrs.push_back(a2);
        exp_addrs.push_back(a3);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_start"},   {31'h0, sd.sd_start}, 32'h0);
        check({tag, "_valid"},   {31'h0, sd.sd_byte_valid}, 32'h0);
        check({tag, "_byte"},    {24'h0, sd.sd_byte}, 32'h0);
        check({tag, "_drops"},   {16'h0, drop_count}, 32'h0);
        check({tag, "_blocks"},  {16'h0, blocks_written}, 32'h0);
        check({tag, "_addr"},    sd.sd_addr, 32'd2048);
        check({tag, "_busy"},    {31'h0, busy}, 32'h0);
    endtask

    initial begin
        int s0;
        int b0;
        int n;

        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Basic capture: four blocks, address wraps after 2050.
        push_addrs(32'd2048, 32'd2049, 32'd2050, 32'd2048);
        pulse_trigger();
        send(2048, 0, 0, 2048, -1);
        wait_idle(5000);
        check("t1_blocks", {16'h0, blocks_written}, 32'd4);
        check("t1_drops",  {16'h0, drop_count}, 32'd0);
        check("t1_starts", starts_seen, 32'd4);

        // Controller stalled: FIFO fills to 1024, remaining 976 strobes are dropped.
        push_addrs(32'd2049, 32'd2050, 32'd2048, 32'd2049);
        ready_en = 1'b0;
        pulse_trigger();
        send(2000, 0, 0, 1024, -1);
        repeat (5) @(negedge clk);
        check("t2_drops",       {16'h0, drop_count}, 32'd976);
        check("t2_busy",        {31'h0, busy}, 32'h1);
        check("t2_blocks_hold", {16'h0, blocks_written}, 32'd4);
        check("t2_starts_hold", starts_seen, 32'd4);
        zero_pend++;
        stray_req = 1'b1;
        @(negedge clk);
        stray_req  = 1'b0;
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
        repeat (3) @(negedge clk);
        check("t2_done_in_start", {16'h0, blocks_written}, 32'd4);
        check("t2_stray_seen", zero_pend, 32'd0);
        s0 = starts_seen;
        ready_en = 1'b1;
        n = 0;
        while (starts_seen == s0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t2_start_after_ready", starts_seen, s0 + 1);
        repeat (10) @(negedge clk);
        send(1024, 2000, 1, 1024, -1);
        wait_idle(5000);
        check("t2_blocks", {16'h0, blocks_written}, 32'd8);
        check("t2_drops_final", {16'h0, drop_count}, 32'd976);
        check("t2_starts", starts_seen, 32'd8);

        // Re-trigger while busy is ignored; a later edge continues at the next address.
        push_addrs(32'd2050, 32'd2048, 32'd2049, 32'd2050);
        pulse_trigger();
        send(2048, 7, 0, 2048, 700);
        wait_idle(5000);
        check("t3_blocks", {16'h0, blocks_written}, 32'd12);
        check("t3_starts", starts_seen, 32'd12);
        push_addrs(32'd2048, 32'd2049, 32'd2050, 32'd2048);
        pulse_trigger();
        send(2048, 8'h40, 0, 2048, -1);
        wait_idle(5000);
        check("t3b_blocks", {16'h0, blocks_written}, 32'd16);
        check("t3b_starts", starts_seen, 32'd16);

        // Reset in the middle of a block.
        exp_addrs.push_back(32'd2049);
        b0 = bytes_seen;
        pulse_trigger();
        send(600, 8'h11, 0, 600, -1);
        n = 0;
        while (bytes_seen < b0 + 100 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("t4_reached_100", {31'h0, bytes_seen >= b0 + 100}, 32'h1);
        rst = 1'b1;
        exp_bytes.delete();
        exp_addrs.delete();
        zero_pend = 0;
        @(posedge clk);
        #1;
        check_reset_state("midrst");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        s0 = starts_seen;
        repeat (3000) @(negedge clk);
        check("t4_no_start", starts_seen, s0);
        check("t4_idle", {31'h0, busy}, 32'h0);

        // Stray byte request and sd_done while idle.
        zero_pend++;
        stray_req = 1'b1;
        @(negedge clk);
        stray_req  = 1'b0;
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
        repeat (3) @(negedge clk);
        check("t5_stray_seen", zero_pend, 32'd0);
        check("t5_blocks", {16'h0, blocks_written}, 32'd0);
        check("t5_addr", sd.sd_addr, 32'd2048);
        check("t5_busy", {31'h0, busy}, 32'h0);

        // Fresh capture after reset starts at the base address again.
        push_addrs(32'd2048, 32'd2049, 32'd2050, 32'd2048);
        pulse_trigger();
        send(2048, 8'h80, 0, 2048, -1);
        wait_idle(5000);
        check("t6_blocks", {16'h0, blocks_written}, 32'd4);

        repeat (5) @(negedge clk);
        check("left_bytes", exp_bytes.size(), 32'd0);
        check("left_addrs", exp_addrs.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sd_capture_scheduler.md
Name: sd_capture_scheduler

Overview:
- Sequences triggered ADC capture into the SD card. Buffers 8-bit samples after a trigger rising edge and groups them into 512-byte blocks.
- Drives the block-write interface of the SD card controller and advances the block address after each block.
- Sits between the ADC/minmax trigger path and sd_card_controller. It is the only writer to the card.

Parameters:
- FIFO_DEPTH, 1024, sample FIFO depth in bytes; power of two, at least 512.
- CAPTURE_BLOCKS, 16, number of 512-byte blocks per trigger event.
- BASE_BLOCK, 32'd2048, first SD block address of the capture region.
- REGION_BLOCKS, 32'd65536, size of the capture region in blocks; the address wraps inside it.

Ports:
- clk  in  1  system clock (sys_clk domain); the only clock.
- rst  in  1  synchronous, active-high reset.
- trigger  in  1  level from minmax_filter; a rising edge starts a capture.
- axiiv  in  1  sample valid; one-cycle strobe from the ADC.
- axiid  in  8  sample data.
- sd_ready  in  1  controller idle and able to accept a write.
- sd_start  out  1  one-cycle write-start pulse.
- sd_addr  out  32  block address; stable from sd_start until sd_done.
- sd_byte_req  in  1  controller requests the next byte (pulse).
- sd_byte  out  8  data byte.
- sd_byte_valid  out  1  high for one cycle, with sd_byte, one cycle after sd_byte_req.
- sd_done  in  1  pulse when the block write completes.
- busy  out  1  capture active, or FIFO not empty, or writer not idle.
- drop_count  out  16  saturating count of samples dropped because the FIFO was full.
- blocks_written  out  16  wrapping count of completed blocks since reset.

Behaviour:
- Reset values: sd_start=0, sd_byte_valid=0, sd_byte=0, drop_count=0, blocks_written=0, sd_addr=BASE_BLOCK, busy=0.
  - FIFO is flushed, capture is inactive, writer is in W_IDLE.
  - Reset mid-operation aborts immediately; no further sd_start is issued.
- Trigger edge detect: trigger is registered and the edge is trigger & ~trigger_q.
  - An edge starts a capture only when busy=0.
  - Edges while busy=1 are ignored; they are not queued.
- Capture side:
  - While active, each axiiv with FIFO not full pushes axiid.
  - A 13+-bit enqueued counter counts pushes. Capture ends on the cycle the push count reaches CAPTURE_BLOCKS*512.
  - axiiv while the FIFO is full drops the sample. The sample is not counted toward the length, and drop_count increments (saturating at 0xFFFF).
  - Samples arriving while capture is inactive are ignored.
- Writer FSM:
  - W_IDLE -> W_START when FIFO count >= 512.
  - W_START: when sd_ready=1, pulse sd_start for one cycle, load byte_cnt=0, go to W_STREAM.
  - W_STREAM: each sd_byte_req pops one byte. sd_byte and sd_byte_valid are registered, so the byte appears the next cycle.
    - After the 512th pop, go to W_WAIT_DONE.
    - A 512 byte count guarantees the FIFO never underflows within a block.
  - W_WAIT_DONE: on sd_done, blocks_written+1 and advance sd_addr, then go to W_IDLE.
    - sd_addr advances by 1. If the result equals BASE_BLOCK+REGION_BLOCKS it wraps to BASE_BLOCK.
  - sd_done in any other state is ignored.
  - sd_byte_req outside W_STREAM returns sd_byte_valid with 0x00 and does not pop.
- A push and a pop in the same cycle are both performed; the count is unchanged. A push is allowed only if not full before the pop.
- sd_addr persists across captures, so consecutive captures append.
- busy is combinational: capture_active | fifo_count!=0 | writer state != W_IDLE.

Decomposition:
- Package sd_capture_pkg holds:
  - the writer state enum (W_IDLE, W_START, W_STREAM, W_WAIT_DONE);
  - localparam SD_BLOCK_BYTES=512.
- Sub-module sync_fifo: parameterised WIDTH/DEPTH, with push, pop, registered dout, full, empty and count.

Test Plan:
- Trigger edge, 1024 back-to-back samples 0x00..0xFF repeating, model controller → two sd_start pulses at addresses 2048 and 2049, each block's 512 bytes in order, blocks_written=2, busy falls after the second sd_done (CAPTURE_BLOCKS=2).
- Hold sd_ready=0 for 2000 sample strobes (FIFO_DEPTH=1024) → exactly 1024 samples stored, drop_count equal to the remaining strobes, capture completes only after the refill once sd_ready rises.
- Second trigger edge mid-capture → ignored; total sd_start count equals CAPTURE_BLOCKS; a later edge with busy=0 starts at the next address.
- REGION_BLOCKS=3, three captures of 2 blocks → addresses 2048, 2049, 2050, 2048, 2049, 2050.
- Assert rst during W_STREAM after 100 bytes → outputs at reset values next cycle, FIFO empty, no sd_start until a new trigger edge.
- sd_byte_req after 512 bytes and sd_done in W_IDLE → sd_byte=0x00 with sd_byte_valid, no FIFO pop, no blocks_written change.
